// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio voice scheduler.
// AUDIO_DUCK_EN (used by audio_voice_scheduler) enables music ducking.
package audio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        SAT,
        WAIT,
        WRITE
    } sched_state_e;

    localparam int GAIN_W     = 4;
    localparam int GAIN_SHIFT = 4;

    // Headroom for gain bits plus one bit per doubling of voice count.
    function automatic int acc_width(input int num_voices, input int data_w);
        return data_w + GAIN_W + $clog2(num_voices);
    endfunction

    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] x,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/audio_sat_clamp.sv
// Combinational signed clamp from IN_W down to OUT_W bits.
module audio_sat_clamp
    import audio_pkg::*;
#(
    parameter int IN_W  = 38,
    parameter int OUT_W = 32
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    logic signed [63:0] wide;
    logic signed [63:0] sat;
    logic               unused_hi;

    assign wide      = 64'(din);
    assign sat       = saturate(wide, OUT_W);
    assign dout      = sat[OUT_W-1:0];
    assign unused_hi = ^sat[63:OUT_W];

endmodule

// File: rtl/audio_voice_scheduler.sv
// Polls voices once per sample slot, mixes with saturation, writes one sample.
// Define AUDIO_DUCK_EN to halve music (voice 0) whenever an SFX voice plays.
module audio_voice_scheduler
    import audio_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int DATA_W      = 32,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                          CLOCK_50,
    input  logic                          resetn,
    input  logic [NUM_VOICES-1:0]         voice_req,
    input  logic [NUM_VOICES*DATA_W-1:0]  voice_sample,
    input  logic [NUM_VOICES*GAIN_W-1:0]  voice_gain,
    output logic [NUM_VOICES-1:0]         voice_ack,
    input  logic                          mute,
    input  logic                          audio_out_allowed,
    output logic                          write_audio_out,
    output logic signed [DATA_W-1:0]      left_channel_audio_out,
    output logic signed [DATA_W-1:0]      right_channel_audio_out,
    output logic [FRAME_CNT_W-1:0]        frame_count,
    output logic                          busy
);

    localparam int ACC_W  = acc_width(NUM_VOICES, DATA_W);
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int MUS_W  = DATA_W + GAIN_W;
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    sched_state_e             state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] out_q, out_d;
    logic [FRAME_CNT_W-1:0]   fcnt_q, fcnt_d;

    logic signed [DATA_W-1:0] cur_sample;
    logic [GAIN_W-1:0]        cur_gain;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] contrib;
    logic signed [ACC_W-1:0]  mix;
    logic signed [DATA_W-1:0] clamped;

    assign cur_sample = voice_sample[int'(idx_q) * DATA_W +: DATA_W];
    assign cur_gain   = voice_gain[int'(idx_q) * GAIN_W +: GAIN_W];
    assign prod       = PROD_W'(cur_sample)
                      * $signed(PROD_W'({1'b0, cur_gain}));
    assign contrib    = prod >>> GAIN_SHIFT;

`ifdef AUDIO_DUCK_EN
    // Music is collected first but can only be scaled once SFX activity is known.
    logic signed [MUS_W-1:0] music_q, music_d;
    logic                    duck_q, duck_d;

    assign mix = acc_q
               + ACC_W'(duck_q ? music_q - (music_q >>> 1) : music_q);
`else
    assign mix = acc_q;
`endif

    audio_sat_clamp #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W)
    ) u_clamp (
        .din  (mix),
        .dout (clamped)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        out_d     = out_q;
        fcnt_d    = fcnt_q;
        voice_ack = '0;
`ifdef AUDIO_DUCK_EN
        music_d   = music_q;
        duck_d    = duck_q;
`endif
        unique case (state_q)
            IDLE: begin
                acc_d = '0;
                idx_d = '0;
`ifdef AUDIO_DUCK_EN
                music_d = '0;
                duck_d  = 1'b0;
`endif
                if (audio_out_allowed) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (voice_req[idx_q]) begin
                    voice_ack[idx_q] = 1'b1;
`ifdef AUDIO_DUCK_EN
                    if (idx_q == '0) begin
                        music_d = MUS_W'(contrib);
                    end else begin
                        acc_d  = acc_q + ACC_W'(contrib);
                        duck_d = 1'b1;
                    end
`else
                    acc_d = acc_q + ACC_W'(contrib);
`endif
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = SAT;
                end
            end
            SAT: begin
                out_d   = mute ? '0 : clamped;
                state_d = WAIT;
            end
            WAIT: begin
                if (audio_out_allowed) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                fcnt_d  = fcnt_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            fcnt_q  <= '0;
`ifdef AUDIO_DUCK_EN
            music_q <= '0;
            duck_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            fcnt_q  <= fcnt_d;
`ifdef AUDIO_DUCK_EN
            music_q <= music_d;
            duck_q  <= duck_d;
`endif
        end
    end

    assign write_audio_out         = (state_q == WRITE);
    assign busy                    = (state_q != IDLE);
    assign left_channel_audio_out  = out_q;
    assign right_channel_audio_out = out_q;
    assign frame_count             = fcnt_q;

endmodule

// File: tb/tb_audio_voice_scheduler.sv
// Directed plus randomized frames checked against a frame-level mixing model.
// Runs with a narrow frame counter so the wrap is reached quickly.
module tb_audio_voice_scheduler;

    localparam int NV  = 4;
    localparam int DW  = 32;
    localparam int FCW = 6;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic [NV-1:0]         voice_req;
    logic [NV*DW-1:0]      voice_sample;
    logic [NV*4-1:0]       voice_gain;
    logic [NV-1:0]         voice_ack;
    logic                  mute;
    logic                  allowed;
    logic                  write_out;
    logic signed [DW-1:0]  left_out;
    logic signed [DW-1:0]  right_out;
    logic [FCW-1:0]        frame_count;
    logic                  busy;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     wr_seen = 0;
    int     exp_wr = 0;
    int     exp_fc = 0;
    int     frames_since_reset = 0;
    longint prev_out = 0;
    longint smp[NV];
    int     gn[NV];

    audio_voice_scheduler #(
        .NUM_VOICES  (NV),
        .DATA_W      (DW),
        .FRAME_CNT_W (FCW)
    ) dut (
        .CLOCK_50                (clk),
        .resetn                  (resetn),
        .voice_req               (voice_req),
        .voice_sample            (voice_sample),
        .voice_gain              (voice_gain),
        .voice_ack               (voice_ack),
        .mute                    (mute),
        .audio_out_allowed       (allowed),
        .write_audio_out         (write_out),
        .left_channel_audio_out  (left_out),
        .right_channel_audio_out (right_out),
        .frame_count             (frame_count),
        .busy                    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write_out === 1'b1) begin
            wr_seen <= wr_seen + 1;
        end
    end

    task automatic check(input string tag,
                         input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint floor_div(input longint p, input longint d);
        longint q;
        q = p / d;
        if ((p % d != 0) && ((p < 0) != (d < 0))) begin
            q = q - 1;
        end
        return q;
    endfunction

    // Mix of the voices that were acknowledged this frame.
    function automatic longint model_mix(input logic [NV-1:0] acked,
                                         input logic m);
        longint part[NV];
        longint total;
        longint lim;
        total = 0;
        lim   = longint'(1) << (DW - 1);
        for (int k = 0; k < NV; k++) begin
            part[k] = acked[k] ? floor_div(smp[k] * gn[k], 16) : 0;
        end
`ifdef AUDIO_DUCK_EN
        if (|acked[NV-1:1]) begin
            part[0] = part[0] - floor_div(part[0], 2);
        end
`endif
        for (int k = 0; k < NV; k++) begin
            total += part[k];
        end
        if (total > lim - 1) total = lim - 1;
        if (total < -lim) total = -lim;
        return m ? 0 : total;
    endfunction

    function automatic longint rand_sample();
        logic signed [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'sh7FFF_FFFF;
            1: v = 32'sh8000_0000;
            2: v = $signed($urandom_range(0, 4000)) - 32'sd2000;
            default: v = $urandom;
        endcase
        return longint'(v);
    endfunction

    // Entered just after a rising edge with the DUT idle; leaves it the same way.
    task automatic run_frame(input logic [NV-1:0] req,
                             input logic [NV-1:0] late,
                             input logic m,
                             input int stall,
                             input string tag);
        logic [NV-1:0] acked;
        longint        expv;
        acked = req & ~late;
        expv  = model_mix(acked, m);
        for (int k = 0; k < NV; k++) begin
            voice_sample[k*DW +: DW] = smp[k][DW-1:0];
            voice_gain[k*4 +: 4]     = gn[k][3:0];
        end
        mute      = m;
        allowed   = 1'b1;
        voice_req = acked;
        @(negedge clk);
        check($sformatf("%s.idle_busy", tag), busy, 0);
        check($sformatf("%s.idle_ack", tag), voice_ack, 0);
        check($sformatf("%s.idle_hold", tag), left_out, prev_out);
        for (int j = 0; j < NV; j++) begin
            step();
            for (int k = 0; k < NV; k++) begin
                voice_req[k] = req[k] & (!late[k] || j > k);
            end
            @(negedge clk);
            check($sformatf("%s.ack%0d", tag, j), voice_ack,
                  acked[j] ? (1 << j) : 0);
            check($sformatf("%s.hold%0d", tag, j), left_out, prev_out);
            check($sformatf("%s.nowr%0d", tag, j), write_out, 0);
        end
        step();
        allowed = (stall == 0);
        @(negedge clk);
        check($sformatf("%s.sat_wr", tag), write_out, 0);
        check($sformatf("%s.sat_hold", tag), left_out, prev_out);
        step();
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check($sformatf("%s.wait_l", tag), left_out, expv);
            check($sformatf("%s.wait_wr", tag), write_out, 0);
            check($sformatf("%s.wait_busy", tag), busy, 1);
            step();
        end
        allowed = 1'b1;
        @(negedge clk);
        check($sformatf("%s.left", tag), left_out, expv);
        check($sformatf("%s.right", tag), right_out, expv);
        check($sformatf("%s.pre_wr", tag), write_out, 0);
        step();
        allowed = 1'b0;
        @(negedge clk);
        check($sformatf("%s.write", tag), write_out, 1);
        check($sformatf("%s.fc_pre", tag), frame_count, exp_fc);
        step();
        exp_fc = (exp_fc + 1) % (1 << FCW);
        exp_wr++;
        frames_since_reset++;
        @(negedge clk);
        check($sformatf("%s.post_wr", tag), write_out, 0);
        check($sformatf("%s.fc", tag), frame_count, exp_fc);
        check($sformatf("%s.busy_end", tag), busy, 0);
        check($sformatf("%s.wr_count", tag), wr_seen, exp_wr);
        check($sformatf("%s.out_keep", tag), left_out, expv);
        prev_out = expv;
        step();
    endtask

    task automatic set_all(input longint s, input int g);
        for (int k = 0; k < NV; k++) begin
            smp[k] = s;
            gn[k]  = g;
        end
    endtask

    initial begin
        logic [NV-1:0] r_req;
        logic [NV-1:0] r_late;
        logic          r_mute;
        int            r_stall;

        resetn       = 1'b0;
        voice_req    = '0;
        voice_sample = '0;
        voice_gain   = '0;
        mute         = 1'b0;
        allowed      = 1'b0;
        set_all(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.write", write_out, 0);
        check("rst.left", left_out, 0);
        check("rst.right", right_out, 0);
        check("rst.fc", frame_count, 0);
        check("rst.ack", voice_ack, 0);
        resetn = 1'b1;
        step();

        set_all(12345, 9);
        smp[0] = 1600;
        gn[0]  = 8;
        run_frame(4'b0001, 4'b0000, 1'b0, 0, "single");

        // Abandon a frame part-way through collection.
        allowed   = 1'b1;
        voice_req = '1;
        step();
        step();
        step();
        #2;
        resetn = 1'b0;
        #1;
        check("midrst.busy", busy, 0);
        check("midrst.write", write_out, 0);
        check("midrst.left", left_out, 0);
        check("midrst.right", right_out, 0);
        check("midrst.fc", frame_count, 0);
        check("midrst.ack", voice_ack, 0);
        allowed = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < NV + 6; i++) begin
            step();
        end
        check("midrst.nowrite", wr_seen, exp_wr);
        check("midrst.idle", busy, 0);
        exp_fc             = 0;
        prev_out           = 0;
        frames_since_reset = 0;

        set_all(longint'(32'sh7FFF_FFFF), 15);
        run_frame(4'b1111, 4'b0000, 1'b0, 0, "satpos");
        set_all(-longint'(1) <<< 31, 15);
        run_frame(4'b1111, 4'b0000, 1'b0, 0, "satneg");

        set_all(0, 0);
        for (int k = 0; k < NV; k++) begin
            smp[k] = rand_sample();
            gn[k]  = $urandom_range(1, 15);
        end
        run_frame(4'b0101, 4'b0000, 1'b0, 10, "backpr");
        run_frame(4'b0101, 4'b0000, 1'b1, 0, "mute");
        run_frame(4'b1111, 4'b1010, 1'b0, 0, "late");
        run_frame(4'b1111, 4'b0000, 1'b0, 0, "held1");
        run_frame(4'b1111, 4'b0000, 1'b0, 0, "held2");

        set_all(-30000, 15);
        gn[1] = 0;
        run_frame(4'b0010, 4'b0000, 1'b0, 0, "gain0");

        set_all(0, 0);
        smp[0] = 1000;
        smp[1] = 1000;
        gn[0]  = 15;
        gn[1]  = 15;
        run_frame(4'b0011, 4'b0000, 1'b0, 0, "duck");
        run_frame(4'b0001, 4'b0000, 1'b0, 0, "musiconly");

        while (frames_since_reset < (1 << FCW) + 6) begin
            for (int k = 0; k < NV; k++) begin
                smp[k] = rand_sample();
                gn[k]  = $urandom_range(0, 15);
            end
            r_req   = NV'($urandom);
            r_late  = ($urandom_range(0, 3) == 0) ? NV'($urandom) : '0;
            r_mute  = ($urandom_range(0, 7) == 0);
            r_stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            run_frame(r_req, r_late, r_mute, r_stall, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_voice_scheduler.md
Name: audio_voice_scheduler

Overview:
- Time-multiplexes up to NUM_VOICES audio voices (music generator, hit/miss/combo SFX) onto the single stereo write port of the board audio controller.
- Once per sample slot (audio_out_allowed high), polls each voice in fixed order, acknowledges and gain-scales its sample, and accumulates with saturation.
- Then issues exactly one write_audio_out pulse with a stable mixed sample.
- Sits between the sound generators and Audio_Controller; replaces ad-hoc summing in the top level.

Parameters:
- NUM_VOICES, 4, number of voice requesters; voice 0 is the music voice.
- DATA_W, 32, signed sample width in and out.
- FRAME_CNT_W, 16, width of the frame_count output.

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- voice_req  in  NUM_VOICES  voice i has a valid sample for this slot
- voice_sample  in  NUM_VOICES*DATA_W  packed signed samples; voice i is at [i*DATA_W +: DATA_W]
- voice_gain  in  NUM_VOICES*4  packed unsigned gains 0..15
- voice_ack  out  NUM_VOICES  one-cycle pulse: voice i's sample was consumed
- mute  in  1  game_over/mute; forces silence but keeps the handshake running
- audio_out_allowed  in  1  from Audio_Controller: output FIFO has space
- write_audio_out  out  1  one-cycle write strobe to Audio_Controller
- left_channel_audio_out  out  DATA_W  mixed sample, registered
- right_channel_audio_out  out  DATA_W  identical to left
- frame_count  out  FRAME_CNT_W  number of completed writes, wraps
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, resetn=0): state=IDLE, acc=0, voice_ack=0, write_audio_out=0, both channel outputs=0, frame_count=0, busy=0.
- FSM states: IDLE, COLLECT, SAT, WAIT, WRITE.
- IDLE: if audio_out_allowed=1, go to COLLECT with idx=0 and acc=0; otherwise stay.
- COLLECT: one cycle per voice, idx=0..NUM_VOICES-1.
  - If voice_req[idx]=1: voice_ack[idx]=1 that cycle, and acc += (sample*gain)>>>4 (arithmetic shift, truncates toward -inf).
  - Requests not present on a voice's own cycle are missed for this frame; they are never retroactively acked.
  - After idx=NUM_VOICES-1, go to SAT.
- acc width is DATA_W+4+clog2(NUM_VOICES) signed; no intermediate overflow.
- SAT: clamp acc to [-(2^(DATA_W-1)), 2^(DATA_W-1)-1]. If mute=1, force the result to 0. Load the result into both channel registers, then go to WAIT.
- WAIT: if audio_out_allowed=1, go to WRITE; else hold. Channel outputs stay stable.
- WRITE: write_audio_out=1 for exactly this cycle, frame_count+1 (wraps at 2^FRAME_CNT_W-1 to 0), then go to IDLE.
- The earliest next frame starts the cycle after WRITE.
- Latency: from IDLE seeing allowed=1 to the write pulse is NUM_VOICES+3 cycles, given allowed stays high.
- Channel outputs change only in SAT and hold their value between frames.
- Gain 0 gives a zero contribution, but the voice is still acked.
- A voice_req held high across frames is acked once per frame.
- mute does not suppress acks, so generators keep advancing.
- Reset mid-frame: partial acc is discarded and no write is issued.

Optional Feature:
- Macro: AUDIO_DUCK_EN.
- Defined:
  - Registers a flag, set in COLLECT when any voice 1..NUM_VOICES-1 is acked.
  - In SAT, if the flag is set, voice 0's contribution is subtracted by half, i.e. music is mixed at half level.
  - Voice 0 is collected first, so its contribution is held separately until SAT.
  - Adds one register of DATA_W+4 bits.
- Undefined: all voices are mixed equally; no extra register.

Decomposition:
- Shared package audio_pkg holds:
  - FSM state enum
  - GAIN_W=4 and GAIN_SHIFT=4
  - a saturate function (signed width reduction)
  - the function computing the accumulator width
- One natural sub-module: audio_sat_clamp, a combinational signed clamp from wide to DATA_W. It is reused by later volume blocks.

Test Plan:
- Reset mid-COLLECT: resetn low at idx=2 → outputs 0, no write_audio_out, frame_count=0.
- Single voice:
  - Stimulus: voice0 sample=1600, gain=8, allowed held high.
  - Required: ack[0] at cycle 1 after start, both channels=800, one write pulse at cycle NUM_VOICES+3, frame_count=1.
- Saturation:
  - Stimulus: all 4 voices sample=0x7FFFFFFF, gain=15.
  - Required: output=0x7FFFFFFF; all negative max samples give 0x80000000.
- Backpressure:
  - Stimulus: allowed drops in SAT for 10 cycles.
  - Required: FSM holds WAIT, outputs stable, a single write when allowed returns, no duplicate write.
- Mute:
  - Stimulus: mute=1 with voices 0 and 2 requesting.
  - Required: acks on both voices, outputs 0, write still pulses.
- Wrap and ducking:
  - frame_count preset near max by running 65536 frames → wraps to 0.
  - With AUDIO_DUCK_EN: voice0=1000 and voice1=1000, both gain 15 (937 each) → 1406.
